// File: rtl/freq_gen_pkg.sv
// rtl/freq_gen_pkg.sv - shared types and constants for the frequency-synthesis sequencer
package freq_gen_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CAL = 3'd1,
        LOAD     = 3'd2,
        COUNT    = 3'd3,
        ERR      = 3'd4
    } fgc_state_t;

    localparam int DEFAULT_TIMEOUT = 4096;
    localparam int K_W             = 8;
    localparam int N_W             = 3;

endpackage

// File: rtl/freq_gen_ctrl_if.sv
// rtl/freq_gen_ctrl_if.sv - sequencer <-> datapath signal bundle (master = sequencer)
interface freq_gen_ctrl_if;
    import freq_gen_pkg::*;

    logic           LdCnt;
    logic           counten;
    logic [N_W-1:0] n;
    logic           kcalc;
    logic [K_W-1:0] k;
    logic           cout;

    modport master (output LdCnt, output counten, output n,
                    input  kcalc, input  k,       input  cout);
    modport slave  (input  LdCnt, input  counten, input  n,
                    output kcalc, output k,       output cout);
endinterface

// File: rtl/fgc_watchdog.sv
// rtl/fgc_watchdog.sv - loadable down-counter used to bound the WAIT_CAL state
module fgc_watchdog #(
    parameter int W = 13
) (
    input  logic         ref_clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Flags the edge on which the count reaches zero, so the caller can act on that same edge.
    assign o_expired = i_en && (r_cnt <= W'(1));
endmodule

// File: rtl/freq_gen_ctrl.sv
// rtl/freq_gen_ctrl.sv - measure/load/count/reload sequencer; optional WAIT_CAL timeout via FREQ_GEN_CTRL_WATCHDOG_EN
module freq_gen_ctrl
    import freq_gen_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int HP_W           = 16
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [N_W-1:0]    n_in,
    freq_gen_ctrl_if.master   dp,
    output logic              busy,
    output logic              running,
    output logic              err,
    output logic [HP_W-1:0]   half_periods
);
    fgc_state_t      r_state;
    logic [N_W-1:0]  r_n;
    logic [HP_W-1:0] r_hp;
    logic            r_loaded;
    logic            w_degenerate;
    logic            w_unused;

    // A load value of 255 would give a zero-length half-period.
    assign w_degenerate = (dp.k[K_W-1:1] == '0);

`ifdef FREQ_GEN_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    logic w_wd_clear;
    logic w_wd_expired;

    assign w_wd_clear = (r_state == IDLE || r_state == ERR) && start && !stop;

    fgc_watchdog #(.W(WD_W)) u_watchdog (
        .ref_clk    (ref_clk),
        .rst        (rst),
        .i_clear    (w_wd_clear),
        .i_load_val (WD_W'(TIMEOUT_CYCLES - 1)),
        .i_en       (r_state == WAIT_CAL),
        .o_expired  (w_wd_expired)
    );
    assign w_unused = dp.k[0];
`else
    assign w_unused = dp.k[0] ^ (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_n      <= '0;
            r_hp     <= '0;
            r_loaded <= 1'b0;
        end else if (stop) begin
            r_state  <= IDLE;
            r_loaded <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ERR: begin
                    if (start) begin
                        r_state  <= WAIT_CAL;
                        r_n      <= n_in;
                        r_hp     <= '0;
                        r_loaded <= 1'b0;
                    end
                end
                WAIT_CAL: begin
                    if (dp.kcalc) begin
                        r_state <= LOAD;
`ifdef FREQ_GEN_CTRL_WATCHDOG_EN
                    end else if (w_wd_expired) begin
                        r_state <= ERR;
`endif
                    end
                end
                LOAD: begin
                    if (w_degenerate) begin
                        r_state <= ERR;
                    end else begin
                        r_state  <= COUNT;
                        r_loaded <= 1'b1;
                        if (r_hp != '1) begin
                            r_hp <= r_hp + 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (dp.cout) begin
                        r_state <= LOAD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Counting stops on terminal count so the datapath counter never wraps before reload.
    assign dp.LdCnt   = (r_state == LOAD);
    assign dp.counten = (r_state == COUNT) && !dp.cout;
    assign dp.n       = r_n;

    assign busy         = (r_state != IDLE);
    assign running      = (r_state == COUNT) || ((r_state == LOAD) && r_loaded);
    assign err          = (r_state == ERR);
    assign half_periods = r_hp;
endmodule

// File: tb/tb_freq_gen_ctrl.sv
// tb/tb_freq_gen_ctrl.sv - directed self-checking bench for freq_gen_ctrl with a behavioural datapath counter
module tb_freq_gen_ctrl;
    logic        ref_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic [2:0]  n_in    = 3'd0;
    logic        busy, running, err;
    logic [15:0] half_periods;
    logic [7:0]  r_dp_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    freq_gen_ctrl_if dp ();

    freq_gen_ctrl #(.TIMEOUT_CYCLES(16), .HP_W(16)) dut (
        .ref_clk      (ref_clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .n_in         (n_in),
        .dp           (dp),
        .busy         (busy),
        .running      (running),
        .err          (err),
        .half_periods (half_periods)
    );

    always #5 ref_clk = ~ref_clk;

    // Datapath model: load 255-(k>>1), count up, terminal count at 255.
    always_ff @(posedge ref_clk) begin
        if (dp.LdCnt)
            r_dp_cnt <= 8'd255 - {1'b0, dp.k[7:1]};
        else if (dp.counten)
            r_dp_cnt <= r_dp_cnt + 8'd1;
    end
    assign dp.cout = (r_dp_cnt == 8'd255);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge ref_clk);
    endtask

    // Measures one LOAD-to-LOAD interval starting from a LOAD cycle.
    task automatic measure(output int cycles, output int ce);
        cycles = 0;
        ce     = 0;
        do begin
            @(negedge ref_clk);
            cycles++;
            ce += int'(dp.counten);
        end while (!dp.LdCnt && cycles < 50);
    endtask

    initial begin
        int cycles, ce, seen;
        r_dp_cnt = 8'd0;
        dp.kcalc = 1'b0;
        dp.k     = 8'd8;

        cyc(2);
        chk("reset_outs", {dp.LdCnt, dp.counten, busy, running, err}, 5'b0);
        chk("reset_n", dp.n, 3'd0);
        chk("reset_hp", half_periods, 16'd0);

        rst = 1'b0;
        dp.kcalc = 1'b1;
        n_in = 3'd3;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("wait_cal_busy", {busy, dp.LdCnt, dp.counten}, 3'b100);
        chk("n_latched", dp.n, 3'd3);
        cyc(1);
        chk("first_load", {dp.LdCnt, dp.counten, running}, 3'b100);
        chk("hp_first_load", half_periods, 16'd0);

        for (int i = 0; i < 3; i++) begin
            measure(cycles, ce);
            chk("period_k8", cycles, 6);
            chk("counten_k8", ce, 4);
            chk("hp_incr", half_periods, i + 1);
            chk("running_reload", running, 1'b1);
        end

        cyc(1);
        dp.k = 8'd12;
        n_in = 3'd6;
        measure(cycles, ce);
        chk("period_cur_k8", cycles, 5);
        measure(cycles, ce);
        chk("period_k12", cycles, 8);
        chk("counten_k12", ce, 6);
        chk("n_held_busy", dp.n, 3'd3);

        cyc(2);
        chk("in_count", {dp.counten, running}, 2'b11);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_idle", {busy, running, dp.counten, dp.LdCnt}, 4'b0);

        dp.k = 8'd8;
        n_in = 3'd5;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("restart_n5", dp.n, 3'd5);
        chk("restart_hp_clr", half_periods, 16'd0);

        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        chk("start_stop_busy", busy, 1'b0);
        cyc(1);
        chk("start_stop_idle", busy, 1'b0);
        start = 1'b0;
        stop  = 1'b0;

        dp.k = 8'd1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        chk("degen_load", dp.LdCnt, 1'b1);
        cyc(1);
        chk("degen_err", {err, busy}, 2'b11);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            seen += int'(dp.LdCnt) + int'(dp.counten) + int'(!err);
        end
        chk("err_held_quiet", seen, 0);

        dp.k = 8'd8;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("err_restart", {busy, err}, 2'b10);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_from_wait", busy, 1'b0);

        dp.kcalc = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
`ifdef FREQ_GEN_CTRL_WATCHDOG_EN
        cycles = 1;
        while (!err && cycles < 100) begin
            cyc(1);
            cycles++;
        end
        chk("watchdog_cycles", cycles, 16);
`else
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            seen += int'(dp.LdCnt) + int'(err) + int'(!busy);
        end
        chk("wait_forever", seen, 0);
        dp.kcalc = 1'b1;
        cyc(1);
        chk("late_kcalc_load", dp.LdCnt, 1'b1);
`endif
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;

        dp.kcalc = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        chk("pre_rst_count", {dp.counten, busy}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", {dp.LdCnt, dp.counten, busy, running, err}, 5'b0);
        chk("async_rst_n_hp", {13'd0, dp.n, half_periods}, 32'd0);
        #1 rst = 1'b0;
        cyc(2);
        chk("post_rst_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
